playback_interp: RTL and testbench
==================================

# playback_interp

Playback sample-rate stage between the SRAM read path and the DAC serializer. Pulls 16-bit signed samples from the SRAM reader over a valid/ready handshake. Emits one sample per DAC frame request. In slow-playback mode each stored sample spans `ratio` output frames, either by zero-order hold or by linear interpolation between consecutive samples.

## Interface

Parameters: none.

Ports:
- `clk` in 1: audio bit clock domain (AUD_BCLK).
- `reset` in 1: synchronous, active-low.
- `ratio` in 4: slow factor, valid 1..8. 0 is treated as 1; values above 8 as 8.
- `slow` in 1: slow-playback enable.
- `interp` in 1: 1 = linear interpolation, 0 = zero-order hold.
- `pause` in 1: freeze output and state.
- `stop` in 1: flush and idle.
- `in_valid` in 1: upstream sample valid.
- `in_data` in 16: upstream sample, two's complement.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `out_req` in 1: one-cycle pulse per DAC frame.
- `out_data` out 16: current DAC sample.
- `underrun` out 1: one-cycle pulse when `out_req` arrives with no result ready.

## Operation

- Internal registers:
  - `prev` and `cur` (16b).
  - Phase `k` (3b).
  - Latched ratio `r` (4b).
  - `next_out` (16b).
- States: IDLE, FILL0, FILL1, CALC, READY, FETCH.
  - IDLE: entered while `stop`=1. `in_ready`=0, `out_data`=0, and prev/cur/k/next_out are cleared. Goes to FILL0 on the first cycle with `stop`=0.
  - FILL0: `in_ready`=1. A transfer (`in_valid`&`in_ready`) loads `prev`, then the state goes to FILL1.
  - FILL1: `in_ready`=1. A transfer loads `cur`, latches `r` (ratio when `slow`=1, else 1), sets k=0, then goes to CALC.
  - CALC: computes `next_out`, then goes to READY.
  - READY: waits for `out_req`.
    - On `out_req`: `out_data`<=`next_out` and k<=k+1.
    - If k+1==r: k<=0 and go to FETCH.
    - Otherwise go to CALC.
  - FETCH: `in_ready`=1. A transfer sets prev<=cur, cur<=in_data, relatches `r`, then goes to CALC.
- `next_out` computation:
  - Hold mode (interp=0, or slow=0): `next_out`=prev.
  - Interp mode: `next_out`=prev + (k·(cur−prev))/r.
    - Diff is 17-bit signed; the product is 20-bit signed.
    - Division runs on the magnitude with a restoring divider; the sign is reapplied, giving truncation toward zero.
    - The result always lies between prev and cur, so no saturation is needed.
- Ratio changes take effect only at the FETCH/FILL1 relatch, never mid-sample.
- `in_ready` is asserted only in FILL0, FILL1 and FETCH. `in_valid` in any other state is ignored.

## Timing

- Reset values: `out_data`=0, `in_ready`=0, `underrun`=0. State after reset is IDLE.
- `out_data` updates on the cycle after the `out_req` edge (1-cycle latency) and holds between requests.
- CALC duration is 22 cycles with the macro defined, 1 cycle without.
- `out_req` in any state other than READY:
  - `underrun` pulses 1 cycle.
  - `out_data` is unchanged, k does not advance, and the request is dropped.
- `pause`=1:
  - `out_req` is ignored, with no underrun.
  - CALC/FETCH complete normally and the block then parks in READY.
- Priority: `stop` > `pause` > `out_req`.
  - `stop` asserted in any state, including mid-CALC or mid-FETCH, takes effect on the next edge: IDLE and `out_data`=0.
  - `reset` overrides everything.

## Configuration

- `PLAYBACK_INTERP_EN` defined: the divider and interpolation datapath are present. `interp` selects the mode. CALC lasts 22 cycles.
- `PLAYBACK_INTERP_EN` undefined: no divider is built and `interp` is ignored. Output is always zero-order hold. CALC lasts 1 cycle.

## Test plan

- slow=0, feed 100, 200, 300, 400, then pulse `out_req` three times with 50-cycle spacing → `out_data` = 100, 200, 300; `underrun` never asserts.
- slow=1, ratio=4, interp=1, feed 0, 400, 800 → `out_data` = 0, 100, 200, 300, 400, 500, 600, 700.
- slow=1, ratio=3, interp=1, feed 0, −100, −100 → `out_data` = 0, −33, −66, −100 (truncation toward zero).
- slow=1, ratio=3, interp=0, feed 100, 200, 300 → `out_data` = 100, 100, 100, 200, 200, 200.
- `out_req` 5 cycles after a READY→CALC transition (macro defined) → `underrun` pulses once, `out_data` unchanged; `out_req` with `pause`=1 → no change and no underrun.
- Assert `stop` during FETCH → next cycle `out_data`=0 and `in_ready`=0. Release `stop` → `in_ready` rises, two transfers are taken, and output restarts from the first new sample.

Source files
------------

// File: rtl/playback_interp_if.sv
// playback_interp_if: upstream sample stream and DAC frame side.
// Shared by the SRAM reader (master) and the playback stage (slave).
interface playback_interp_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_req;
  logic [15:0] out_data;
  logic        underrun;

  modport master (
    output in_valid, in_data, out_req,
    input  in_ready, out_data, underrun
  );

  modport slave (
    input  in_valid, in_data, out_req,
    output in_ready, out_data, underrun
  );
endinterface

// File: rtl/playback_interp.sv
// playback_interp: sample-rate stage between SRAM reader and DAC.
// PLAYBACK_INTERP_EN adds the divider and linear interpolation.
module playback_interp (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ratio,
  input  logic       slow,
  input  logic       interp,
  input  logic       pause,
  input  logic       stop,
  playback_interp_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FILL0, FILL1, CALC, READY, FETCH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] next_q, next_d;
  logic [15:0] out_q, out_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  r_q, r_d;
  logic        ur_q, ur_d;
  logic [3:0]  r_new;
  logic [3:0]  k_inc;
  logic        xfer;

  // stop drops ready at once so no beat is accepted while flushing
  assign bus.in_ready = !stop &&
    (state_q == FILL0 || state_q == FILL1 || state_q == FETCH);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus.out_data = out_q;
  assign bus.underrun = ur_q;
  assign k_inc        = {1'b0, k_q} + 4'd1;

  // effective ratio: 1 when not slow, clamped to 1..8
  always_comb begin
    r_new = ratio;
    if (!slow || ratio == 4'd0) r_new = 4'd1;
    else if (ratio > 4'd8)      r_new = 4'd8;
  end

`ifdef PLAYBACK_INTERP_EN
  logic [4:0]         cnt_q, cnt_d;
  logic [19:0]        mag_q, mag_d;
  logic [19:0]        quo_q, quo_d;
  logic [3:0]         rem_q, rem_d;
  logic               neg_q, neg_d;
  logic signed [16:0] diff;
  logic signed [19:0] prod;
  logic [4:0]         trial;
  logic [4:0]         sub;
  logic [19:0]        delta;
  logic [19:0]        sum;
  logic               unused_ok;

  assign diff  = $signed({cur_q[15], cur_q})
               - $signed({prev_q[15], prev_q});
  assign prod  = $signed({17'd0, k_q})
               * $signed({{3{diff[16]}}, diff});
  assign trial = {rem_q, mag_q[19]};
  assign sub   = trial - {1'b0, r_q};
  assign delta = neg_q ? (20'd0 - quo_q) : quo_q;
  assign sum   = {{4{prev_q[15]}}, prev_q} + delta;
  // result lies between prev and cur, so the top bits are redundant
  assign unused_ok = ^{sub[4], sum[19:16]};
`else
  logic unused_ok;
  assign unused_ok = interp;
`endif

  // next-state and datapath; stop wins over everything but reset
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    next_d  = next_q;
    out_d   = out_q;
    k_d     = k_q;
    r_d     = r_q;
    ur_d    = bus.out_req && !stop && !pause && state_q != READY;
`ifdef PLAYBACK_INTERP_EN
    cnt_d = (state_q == CALC) ? cnt_q + 5'd1 : 5'd0;
    mag_d = mag_q;
    quo_d = quo_q;
    rem_d = rem_q;
    neg_d = neg_q;
`endif
    if (stop) begin
      state_d = IDLE;
      prev_d  = '0;
      cur_d   = '0;
      next_d  = '0;
      out_d   = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = FILL0;
        FILL0: begin
          if (xfer) begin
            prev_d  = bus.in_data;
            state_d = FILL1;
          end
        end
        FILL1: begin
          if (xfer) begin
            cur_d   = bus.in_data;
            r_d     = r_new;
            k_d     = '0;
            state_d = CALC;
          end
        end
        CALC: begin
`ifdef PLAYBACK_INTERP_EN
          if (cnt_q == 5'd0) begin
            mag_d = prod[19] ? $unsigned(-prod) : $unsigned(prod);
            neg_d = prod[19];
            rem_d = '0;
            quo_d = '0;
          end else if (cnt_q <= 5'd20) begin
            mag_d = {mag_q[18:0], 1'b0};
            if (trial >= {1'b0, r_q}) begin
              rem_d = sub[3:0];
              quo_d = {quo_q[18:0], 1'b1};
            end else begin
              rem_d = trial[3:0];
              quo_d = {quo_q[18:0], 1'b0};
            end
          end else begin
            next_d  = (interp && slow) ? sum[15:0] : prev_q;
            state_d = READY;
          end
`else
          next_d  = prev_q;
          state_d = READY;
`endif
        end
        READY: begin
          if (bus.out_req && !pause) begin
            out_d = next_q;
            if (k_inc == r_q) begin
              k_d     = '0;
              state_d = FETCH;
            end else begin
              k_d     = k_q + 3'd1;
              state_d = CALC;
            end
          end
        end
        FETCH: begin
          if (xfer) begin
            prev_d  = cur_q;
            cur_d   = bus.in_data;
            r_d     = r_new;
            state_d = CALC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      out_q   <= '0;
      k_q     <= '0;
      r_q     <= 4'd1;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      out_q   <= out_d;
      k_q     <= k_d;
      r_q     <= r_d;
      ur_q    <= ur_d;
    end
  end

`ifdef PLAYBACK_INTERP_EN
  // restoring divider registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      mag_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mag_q <= mag_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
    end
  end
`endif

endmodule

// File: tb/tb_playback_interp.sv
// tb_playback_interp: directed vectors for playback_interp.
// Expected values follow the build (PLAYBACK_INTERP_EN or hold only).
module tb_playback_interp;

`ifdef PLAYBACK_INTERP_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ratio;
  logic       slow;
  logic       interp;
  logic       pause;
  logic       stop;

  playback_interp_if bus ();

  playback_interp dut (
    .clk    (clk),
    .reset  (reset),
    .ratio  (ratio),
    .slow   (slow),
    .interp (interp),
    .pause  (pause),
    .stop   (stop),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ur_cnt = 0;
  int          u0;
  int          w;
  logic [15:0] feed_q[$];

  int e3i[4] = '{0, -33, -66, -100};
  int e3h[4] = '{0, 0, 0, -100};
  int e4[6]  = '{100, 100, 100, 200, 200, 200};

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk)
    if (bus.underrun === 1'b1) ur_cnt++;

  // upstream model: present queue head, pop on handshake
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        feed_q.delete(0);
      end
      bus.in_valid = (feed_q.size() != 0);
      bus.in_data  = (feed_q.size() != 0) ? feed_q[0] : 16'd0;
    end
  end

  task automatic req(input string tag, input int gap,
                     input logic signed [31:0] exp);
    repeat (gap) @(posedge clk);
    #1 bus.out_req = 1'b1;
    @(posedge clk);
    #1 bus.out_req = 1'b0;
    chk(tag, $signed(bus.out_data), exp);
    @(negedge clk);
    #1;
  endtask

  task automatic restart(input logic s, input logic [3:0] r,
                         input logic ip);
    stop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    feed_q.delete();
    slow   = s;
    ratio  = r;
    interp = ip;
    pause  = 1'b0;
  endtask

  task automatic go();
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  initial begin
    bus.out_req = 1'b0;
    reset  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    slow   = 1'b0;
    ratio  = 4'd1;
    interp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", $signed(bus.out_data), 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_ur", bus.underrun, 0);
    reset = 1'b1;

    // normal rate
    restart(1'b0, 4'd1, 1'b0);
    feed_q.push_back(16'd100);
    feed_q.push_back(16'd200);
    feed_q.push_back(16'd300);
    feed_q.push_back(16'd400);
    go();
    u0 = ur_cnt;
    req("t1_0", 50, 100);
    req("t1_1", 50, 200);
    req("t1_2", 50, 300);
    chk("t1_ur", ur_cnt - u0, 0);

    // ratio 4 interpolation ramp
    restart(1'b1, 4'd4, 1'b1);
    feed_q.push_back(16'd0);
    feed_q.push_back(16'd400);
    feed_q.push_back(16'd800);
    go();
    for (int i = 0; i < 8; i++)
      req($sformatf("t2_%0d", i), 50,
          IE ? i * 100 : (i < 4 ? 0 : 400));

    // negative step, truncation toward zero
    restart(1'b1, 4'd3, 1'b1);
    feed_q.push_back(16'd0);
    feed_q.push_back(16'hFF9C);
    feed_q.push_back(16'hFF9C);
    go();
    for (int i = 0; i < 4; i++)
      req($sformatf("t3_%0d", i), 50, IE ? e3i[i] : e3h[i]);

    // zero-order hold
    restart(1'b1, 4'd3, 1'b0);
    feed_q.push_back(16'd100);
    feed_q.push_back(16'd200);
    feed_q.push_back(16'd300);
    go();
    for (int i = 0; i < 6; i++)
      req($sformatf("t4_%0d", i), 50, e4[i]);

    // ratio 0 acts as 1
    restart(1'b1, 4'd0, 1'b1);
    feed_q.push_back(16'd5);
    feed_q.push_back(16'd6);
    feed_q.push_back(16'd7);
    go();
    req("c0_0", 50, 5);
    req("c0_1", 50, 6);

    // ratio 12 clamps to 8
    restart(1'b1, 4'd12, 1'b1);
    feed_q.push_back(16'd0);
    feed_q.push_back(16'd800);
    go();
    req("c12_0", 50, 0);
    req("c12_1", 50, IE ? 100 : 0);

    // underrun and pause
    restart(1'b1, 4'd2, 1'b1);
    feed_q.push_back(16'd0);
    feed_q.push_back(16'd100);
    go();
    u0 = ur_cnt;
    req("t5_a", 50, 0);
    req("t5_early", 4, 0);
    chk("t5_ur_early", ur_cnt - u0, IE ? 1 : 0);
    req("t5_b", 50, IE ? 50 : 0);
    chk("t5_ur_b", ur_cnt - u0, 1);
    req("t5_c", 50, IE ? 50 : 0);
    chk("t5_ur_c", ur_cnt - u0, 2);
    pause = 1'b1;
    feed_q.push_back(16'd200);
    req("t5_pause", 50, IE ? 50 : 0);
    chk("t5_ur_pause", ur_cnt - u0, 2);
    pause = 1'b0;
    req("t5_resume", 10, 100);
    chk("t5_ur_end", ur_cnt - u0, 2);

    // stop during fetch, then restart
    restart(1'b0, 4'd1, 1'b0);
    feed_q.push_back(16'd10);
    feed_q.push_back(16'd20);
    go();
    req("t6_0", 50, 10);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_fetch_rdy", bus.in_ready, 1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_stop_out", $signed(bus.out_data), 0);
    chk("t6_stop_rdy", bus.in_ready, 0);
    feed_q.push_back(16'd30);
    feed_q.push_back(16'd40);
    @(posedge clk);
    #1 stop = 1'b0;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("t6_rdy_rise", bus.in_ready, 1);
    req("t6_1", 50, 30);
    feed_q.push_back(16'd50);
    req("t6_2", 50, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
